// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions
// inside the {C,Z,N,V} flag vector, and the control FSM state encoding.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'h00,
        OP_ADC  = 5'h01,
        OP_SUB  = 5'h02,
        OP_SBB  = 5'h03,
        OP_NEG  = 5'h04,
        OP_INC  = 5'h05,
        OP_DEC  = 5'h06,
        OP_PASS = 5'h07,
        OP_AND  = 5'h08,
        OP_OR   = 5'h09,
        OP_XOR  = 5'h0A,
        OP_NOT  = 5'h0B,
        OP_ASH  = 5'h0C,
        OP_LSH  = 5'h0D,
        OP_ROT  = 5'h0E,
        OP_RCC  = 5'h0F,
        OP_MUL  = 5'h10,
        OP_DIV  = 5'h11
    } alu_op_e;

    // Bit positions inside flags = {C,Z,N,V}
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide.
// One iteration per step cycle; done is asserted during the final iteration
// so the parent can register the next-state values (res_lo/res_hi) directly.
// Both ops load hi=0, lo=a, operand=b, so the same registers serve both.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_div,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic                  div_mode,
    output logic                  div_zero,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] res_hi
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic          is_div_q;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic [W-1:0]  opnd_q;
    logic [W:0]    sum;
    logic [W:0]    shifted;
    logic [W-1:0]  diff;
    logic [W-1:0]  nxt_hi;
    logic [W-1:0]  nxt_lo;

    // Iteration counter and op mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
        end else if (start) begin
            cnt      <= CNT_LOAD;
            is_div_q <= is_div;
        end else if (step && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Working registers: load on start, advance one iteration per step
    always_ff @(posedge clk) begin
        if (start) begin
            hi_q   <= '0;
            lo_q   <= a;
            opnd_q <= b;
        end else if (step) begin
            hi_q <= nxt_hi;
            lo_q <= nxt_lo;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        nxt_hi  = hi_q;
        nxt_lo  = lo_q;
        if (is_div_q) begin
            // Remainder stays below the divisor, so a W-bit difference is exact
            // whenever the trial subtraction succeeds. A zero divisor always
            // succeeds, yielding all-ones quotient and remainder = dividend.
            shifted = {hi_q, lo_q[W-1]};
            diff    = shifted[W-1:0] - opnd_q;
            if (shifted >= {1'b0, opnd_q}) begin
                nxt_hi = diff;
                nxt_lo = {lo_q[W-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[W-1:0];
                nxt_lo = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
            nxt_hi = sum[W:1];
            nxt_lo = {sum[0], lo_q[W-1:1]};
        end
    end

    assign done     = step && (cnt == '0);
    assign div_mode = is_div_q;
    assign div_zero = (opnd_q == '0);
    assign res_lo   = nxt_lo;
    assign res_hi   = nxt_hi;

endmodule

// File: rtl/alu_seq.sv
// Parametrised sequential ALU: single-cycle arithmetic/logic/shift unit,
// registered {C,Z,N,V} flags, and an iterative MUL/DIV behind a valid/ready
// input handshake. Carry-in for ADC/SBB/RCC comes from the registered C flag.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            opcode,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] y_hi,
    output logic                  out_valid,
    output logic [3:0]            flags
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_e       state;
    state_e       state_nxt;
    logic         accept;
    logic         is_muldiv;
    logic         md_start;
    logic         md_step;
    logic         md_done;
    logic         md_div;
    logic         md_dz;
    logic [W-1:0] md_lo;
    logic [W-1:0] md_hi;
    logic [W-1:0] x;
    logic         c_in;
    logic [W:0]   wide;
    logic [W-1:0] alu_y;
    logic         alu_c;
    logic         alu_v;
    logic         alu_zn_upd;

    function automatic logic add_ovf(input logic [W-1:0] p, input logic [W-1:0] q,
                                     input logic [W-1:0] r);
        return (p[W-1] == q[W-1]) && (r[W-1] != p[W-1]);
    endfunction

    function automatic logic sub_ovf(input logic [W-1:0] p, input logic [W-1:0] q,
                                     input logic [W-1:0] r);
        return (p[W-1] != q[W-1]) && (r[W-1] != p[W-1]);
    endfunction

    assign accept    = in_valid && in_ready;
    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign md_start  = accept && is_muldiv;
    assign x         = sel ? a : b;
    assign c_in      = flags[FLAG_C];

    alu_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start    (md_start),
        .is_div   (opcode == OP_DIV),
        .step     (md_step),
        .a        (a),
        .b        (b),
        .done     (md_done),
        .div_mode (md_div),
        .div_zero (md_dz),
        .res_lo   (md_lo),
        .res_hi   (md_hi)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: enter BUSY on MUL/DIV accept, leave on final iteration
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (md_start) state_nxt = BUSY;
            BUSY:    if (md_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state == IDLE);
        md_step  = (state == BUSY);
    end

    // Single-cycle unit; C and V default to their registered values
    always_comb begin
        wide       = '0;
        alu_y      = '0;
        alu_c      = c_in;
        alu_v      = flags[FLAG_V];
        alu_zn_upd = 1'b1;
        case (opcode)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
                alu_v = add_ovf(a, b, alu_y);
            end
            OP_ADC: begin
                wide  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
                alu_v = add_ovf(a, b, alu_y);
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
                alu_v = sub_ovf(a, b, alu_y);
            end
            OP_SBB: begin
                wide  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c_in};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
                alu_v = sub_ovf(a, b, alu_y);
            end
            OP_NEG: begin
                wide  = {(W+1){1'b0}} - {1'b0, x};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
                alu_v = sub_ovf({W{1'b0}}, x, alu_y);
            end
            OP_INC: begin
                wide  = {1'b0, x} + {1'b0, ONE};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
                alu_v = add_ovf(x, ONE, alu_y);
            end
            OP_DEC: begin
                wide  = {1'b0, x} - {1'b0, ONE};
                alu_y = wide[W-1:0];
                alu_c = wide[W];
                alu_v = sub_ovf(x, ONE, alu_y);
            end
            OP_PASS: alu_y = x;
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_NOT:  alu_y = ~x;
            OP_ASH: begin
                alu_y = sel ? {a[W-2:0], 1'b0} : {a[W-1], a[W-1:1]};
                alu_c = sel ? a[W-1] : a[0];
            end
            OP_LSH: begin
                alu_y = sel ? {a[W-2:0], 1'b0} : {1'b0, a[W-1:1]};
                alu_c = sel ? a[W-1] : a[0];
            end
            OP_ROT: begin
                alu_y = sel ? {a[W-2:0], a[W-1]} : {a[0], a[W-1:1]};
                alu_c = sel ? a[W-1] : a[0];
            end
            OP_RCC: begin
                alu_y = sel ? {a[W-2:0], c_in} : {c_in, a[W-1:1]};
                alu_c = sel ? a[W-1] : a[0];
            end
            default: alu_zn_upd = 1'b0;
        endcase
    end

    // Result and flag registers: single-cycle ops on accept, MUL/DIV on final iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            y_hi      <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_muldiv) begin
                y             <= alu_y;
                y_hi          <= '0;
                flags[FLAG_C] <= alu_c;
                flags[FLAG_V] <= alu_v;
                if (alu_zn_upd) begin
                    flags[FLAG_Z] <= ~|alu_y;
                    flags[FLAG_N] <= alu_y[W-1];
                end
                out_valid <= 1'b1;
            end else if (md_done) begin
                y             <= md_lo;
                y_hi          <= md_hi;
                flags[FLAG_Z] <= ~|md_lo;
                flags[FLAG_N] <= md_lo[W-1];
                flags[FLAG_V] <= md_div ? md_dz : |md_hi;
                out_valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (DATA_WIDTH=8): the driver pushes expected
// results from an integer-arithmetic reference model; a negedge monitor pops
// and compares value, flags and arrival cycle whenever out_valid is high.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int MOD  = 256;
    localparam int HALF = 128;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcode;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         out_valid;
    logic [3:0]   flags;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .y         (y),
        .y_hi      (y_hi),
        .out_valid (out_valid),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        int yh;
        int f;
        int cyc;
    } exp_t;

    exp_t       expq[$];
    int         obs_y[$];
    int         obs_yh[$];
    int         obs_f[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [3:0] m_flags = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic bit ovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    function automatic int wrap(input int r);
        return ((r % MOD) + MOD) % MOD;
    endfunction

    // Reference model in plain integer arithmetic; f is {C,Z,N,V}
    function automatic void model(input logic [4:0] op, input logic s,
                                  input logic [7:0] av, input logic [7:0] bv,
                                  inout logic [3:0] f, output int ey, output int eyh);
        int ua, ub, ux, sa, sb, sx, r, cin;
        bit c, v, upd;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        ux = s ? ua : ub;
        sx = s ? sa : sb;
        cin = f[3] ? 1 : 0;
        c = f[3];
        v = f[0];
        upd = 1'b1;
        ey = 0;
        eyh = 0;
        case (op)
            OP_ADD:  begin r = ua + ub;       c = (r >= MOD); v = ovf(sa + sb);       ey = r % MOD; end
            OP_ADC:  begin r = ua + ub + cin; c = (r >= MOD); v = ovf(sa + sb + cin); ey = r % MOD; end
            OP_SUB:  begin r = ua - ub;       c = (r < 0);    v = ovf(sa - sb);       ey = wrap(r); end
            OP_SBB:  begin r = ua - ub - cin; c = (r < 0);    v = ovf(sa - sb - cin); ey = wrap(r); end
            OP_NEG:  begin r = -ux;           c = (r < 0);    v = ovf(-sx);           ey = wrap(r); end
            OP_INC:  begin r = ux + 1;        c = (r >= MOD); v = ovf(sx + 1);        ey = r % MOD; end
            OP_DEC:  begin r = ux - 1;        c = (r < 0);    v = ovf(sx - 1);        ey = wrap(r); end
            OP_PASS: ey = ux;
            OP_AND:  ey = ua & ub;
            OP_OR:   ey = ua | ub;
            OP_XOR:  ey = ua ^ ub;
            OP_NOT:  ey = MOD - 1 - ux;
            OP_ASH: begin
                if (s) begin ey = (ua * 2) % MOD; c = (ua >= HALF); end
                else   begin ey = wrap(sa >>> 1); c = (ua % 2 == 1); end
            end
            OP_LSH: begin
                if (s) begin ey = (ua * 2) % MOD; c = (ua >= HALF); end
                else   begin ey = ua / 2;         c = (ua % 2 == 1); end
            end
            OP_ROT: begin
                if (s) begin ey = (ua * 2) % MOD + ua / HALF;   c = (ua >= HALF); end
                else   begin ey = ua / 2 + (ua % 2) * HALF;     c = (ua % 2 == 1); end
            end
            OP_RCC: begin
                if (s) begin ey = (ua * 2) % MOD + cin;         c = (ua >= HALF); end
                else   begin ey = ua / 2 + cin * HALF;          c = (ua % 2 == 1); end
            end
            OP_MUL: begin
                r = ua * ub; ey = r % MOD; eyh = r / MOD; v = (eyh != 0);
            end
            OP_DIV: begin
                if (ub == 0) begin ey = MOD - 1; eyh = ua; v = 1'b1; end
                else         begin ey = ua / ub; eyh = ua % ub; v = 1'b0; end
            end
            default: upd = 1'b0;
        endcase
        f = {c, upd ? (ey == 0) : f[2], upd ? (ey >= HALF) : f[1], v};
    endfunction

    // Drive one op at the negedge once the DUT is ready; it is accepted on the next posedge
    task automatic issue(input logic [4:0] op, input logic s, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int guard;
        int ey, eyh;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready=%0d after %0d cycles", in_ready, guard);
        end
        opcode   = op;
        sel      = s;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        model(op, s, av, bv, m_flags, ey, eyh);
        e.y   = ey;
        e.yh  = eyh;
        e.f   = int'(m_flags);
        e.cyc = cyc + 1 + (((op == OP_MUL) || (op == OP_DIV)) ? W : 0);
        expq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count cycles with in_ready low after a MUL/DIV accept, pulsing junk requests early on
    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            if (n < 3) begin
                in_valid = 1'b1;
                opcode   = OP_ADD;
                a        = 8'h01;
                b        = 8'h01;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (expq.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", expq.size(), 0);
    endtask

    task automatic check_obs(input string nm, input int back, input int ey, input int eyh, input int ef);
        int idx;
        idx = obs_y.size() - 1 - back;
        if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL %s: no result observed", nm);
        end else begin
            chk({nm, "_y"}, obs_y[idx], ey);
            chk({nm, "_y_hi"}, obs_yh[idx], eyh);
            chk({nm, "_flags"}, obs_f[idx], ef);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && out_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("y", int'(y), e.y);
                chk("y_hi", int'(y_hi), e.yh);
                chk("flags", int'(flags), e.f);
                chk("latency_cycle", cyc, e.cyc);
            end
            obs_y.push_back(int'(y));
            obs_yh.push_back(int'(y_hi));
            obs_f.push_back(int'(flags));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [4:0] rop;
        logic [7:0] ra, rb;
        reset    = 1'b1;
        in_valid = 1'b0;
        opcode   = 5'h00;
        sel      = 1'b0;
        a        = '0;
        b        = '0;

        // Reset values
        @(negedge clk);
        chk("rst_y", int'(y), 0);
        chk("rst_y_hi", int'(y_hi), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Add chain, back to back
        issue(OP_ADD, 1'b0, 8'hFF, 8'h01);
        issue(OP_ADC, 1'b0, 8'h10, 8'h20);
        drain();
        check_obs("add_ff_01", 1, 8'h00, 0, 4'hC);
        check_obs("adc_10_20", 0, 8'h31, 0, 4'h0);

        // Subtract overflow then borrow-in of zero
        issue(OP_SUB, 1'b0, 8'h80, 8'h01);
        drain();
        check_obs("sub_80_01", 0, 8'h7F, 0, 4'h1);
        issue(OP_SBB, 1'b0, 8'h00, 8'h00);
        drain();
        check_obs("sbb_00_00", 0, 8'h00, 0, 4'h4);

        // MUL with junk requests while busy
        issue(OP_MUL, 1'b0, 8'h0F, 8'h11);
        count_busy(n);
        chk("mul_busy_cycles", n, W);
        drain();
        check_obs("mul_0f_11", 0, 8'hFF, 8'h00, 4'h2);
        issue(OP_MUL, 1'b0, 8'hFF, 8'hFF);
        drain();
        check_obs("mul_ff_ff", 0, 8'h01, 8'hFE, 4'h1);

        // DIV, normal and by zero, same latency
        issue(OP_DIV, 1'b0, 8'd200, 8'd7);
        count_busy(n);
        chk("div_busy_cycles", n, W);
        drain();
        check_obs("div_200_7", 0, 8'h1C, 8'h04, 4'h0);
        issue(OP_DIV, 1'b0, 8'h5A, 8'h00);
        count_busy(n);
        chk("div0_busy_cycles", n, W);
        drain();
        check_obs("div_5a_0", 0, 8'hFF, 8'h5A, 4'h3);

        // Shifts and rotates (V still set from the divide by zero)
        issue(OP_ASH, 1'b0, 8'h81, 8'h00);
        drain();
        check_obs("ash_r_81", 0, 8'hC0, 0, 4'hB);
        issue(OP_RCC, 1'b0, 8'h02, 8'h00);
        drain();
        check_obs("rcc_r_02", 0, 8'h81, 0, 4'h3);
        issue(OP_ROT, 1'b1, 8'h80, 8'h00);
        drain();
        check_obs("rot_l_80", 0, 8'h01, 0, 4'h9);

        // Reset four cycles into a MUL
        issue(OP_MUL, 1'b0, 8'hC3, 8'h5B);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        expq.delete();
        m_flags = 4'h0;
        #1;
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_y", int'(y), 0);
        chk("post_rst_y_hi", int'(y_hi), 0);
        chk("post_rst_flags", int'(flags), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        repeat (W + 2) @(negedge clk);
        issue(OP_ADD, 1'b0, 8'h01, 8'h01);
        drain();
        check_obs("add_after_rst", 0, 8'h02, 0, 4'h0);

        // Randomised ops, some back to back, some with idle gaps
        for (int i = 0; i < 200; i++) begin
            rop = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rop = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) rb = 8'h00;
            issue(rop, 1'($urandom_range(0, 1)), ra, rb);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU that generalises the 8-bit single-cycle ALU to any `DATA_WIDTH`. It adds registered status flags (C, Z, N, V) and takes carry/borrow from its own C flag, not from an instruction bit. It also adds iterative multiply and divide, with a valid/ready input handshake. It sits between the register file and the writeback mux in the CPU datapath.

## Interface
- `DATA_WIDTH`, 8, operand/result width in bits; legal values are 4 and above.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high when the block can accept; reset value 1.
- `opcode`  in  5  operation code, from `alu_pkg::alu_op_e`.
- `sel`  in  1  selects the operand (1 = `a`, 0 = `b`) for unary ops; selects direction (1 = left, 0 = right) for shifts and rotates.
- `a`, `b`  in  DATA_WIDTH  operands.
- `y`  out  DATA_WIDTH  result, or product low half, or quotient; reset value 0.
- `y_hi`  out  DATA_WIDTH  product high half or remainder; 0 for all other ops; reset value 0.
- `out_valid`  out  1  one-cycle pulse marking `y`/`y_hi`/`flags` as updated; reset value 0.
- `flags`  out  4  registered {C,Z,N,V}; reset value 0.

## Operation
- **Handshake.** An op is accepted on a rising edge with `in_valid && in_ready`. There is no output backpressure; the consumer must capture results on `out_valid`. Inputs presented while `in_ready=0` are ignored, and the source holds them.
- **Opcodes 0x00–0x0F** keep the classic encoding:
  - ADD, ADC, SUB, SBB (C as borrow-in), NEG (true two's complement, ~x+1), INC, DEC, PASS
  - AND, OR, XOR, NOT
  - ASH, LSH, ROT, RCC (rotate through C) on `a`
- **0x10 MUL** is unsigned shift-add. **0x11 DIV** is unsigned restoring division. Opcodes 0x12–0x1F give `y=0`, flags unchanged, `out_valid` pulsed.
- **Arithmetic and widths.**
  - Add/sub are computed at DATA_WIDTH+1 bits.
  - C = carry out for add. For sub, C = borrow (a < b + borrow-in, unsigned).
  - V = signed overflow for add/sub/NEG/INC/DEC.
  - Shifts and rotates: C = the bit shifted out. RCC shifts the old C in.
  - ASH right replicates bit DATA_WIDTH-1. ASH left equals LSH left.
  - AND/OR/XOR/NOT/PASS: C and V unchanged.
  - MUL: V = (y_hi != 0), C unchanged.
  - DIV: C unchanged. Divide by zero gives y = all-ones, y_hi = a, V=1, with the same latency as a normal divide.
  - Z = (y == 0) and N = y[DATA_WIDTH-1], for every result.
- **FSM states.**
  - IDLE: `in_ready=1`. A single-cycle op writes `y`/`flags` and pulses `out_valid`, then stays in IDLE. MUL/DIV loads the working registers, sets the counter to DATA_WIDTH-1, and moves to BUSY.
  - BUSY: `in_ready=0`. One iteration per cycle, counter decrements. When the counter reaches 0, that final iteration writes `y`, `y_hi` and `flags`, pulses `out_valid`, and returns to IDLE.
- **Reset at any time:** the FSM goes to IDLE, any in-flight MUL/DIV is discarded without an `out_valid`, and all outputs take their reset values.

## Timing
- **Single-cycle ops:** latency 1. With the op accepted on edge E0, `out_valid` is high for the cycle after E0. Back-to-back throughput is 1 op/cycle.
- **MUL/DIV:**
  - Accepted on edge E0; iterations run on edges E1..E(DATA_WIDTH).
  - `in_ready` is low from E0 until E(DATA_WIDTH).
  - `out_valid` is high for the cycle after E(DATA_WIDTH), with `in_ready` back at 1 in that same cycle.
  - A new op may be accepted on the edge ending that cycle.
- **Carry timing:** ADC/SBB/RCC use C as registered before the accepting edge. A back-to-back ADC therefore sees the carry from the immediately preceding op.

## Structure
- `alu_pkg`: the `alu_op_e` enum (5-bit), flag index constants `FLAG_C`/`FLAG_Z`/`FLAG_N`/`FLAG_V`, and the `state_e` enum {IDLE, BUSY}.
- Sub-module `alu_muldiv`: iterative multiply/divide datapath and counter, with start, done and operands as ports. `alu_seq` contains the combinational single-cycle unit, the FSM, and the flag register.

## Test plan
- **Add chain:** ADD 0xFF+0x01, then ADC 0x10+0x20 → y=0x00 with C=1, Z=1, V=0; then y=0x31 with C=0. Back-to-back, `out_valid` high two consecutive cycles.
- **Subtract overflow:** SUB 0x80−0x01 → y=0x7F, V=1, C=0, N=0. Then SBB 0x00−0x00 with C=0 → y=0x00, Z=1.
- **MUL:**
  - 0x0F×0x11 → y=0xFF, y_hi=0x00. `in_ready` low 8 cycles; `out_valid` in cycle 9 after acceptance. Input pulses during BUSY are ignored.
  - 0xFF×0xFF → y=0x01, y_hi=0xFE, V=1.
- **DIV:** 200÷7 → y=0x1C, y_hi=0x04, V=0. 0x5A÷0 → y=0xFF, y_hi=0x5A, V=1, with identical latency.
- **Shifts:** ASH right 0x81 → 0xC0, C=1. Then RCC right a=0x02 with C=1 → 0x81, C=0. ROT left 0x80 → 0x01, C=1.
- **Reset mid-MUL:** assert `reset` 4 cycles into a MUL → no `out_valid`; `y`, `y_hi`, `flags` = 0 and `in_ready`=1 after release. A following ADD 0x01+0x01 → y=0x02 with latency 1.
